vid_pattern_gen: RTL and testbench
==================================

VID_PATTERN_GEN -- requirements
Module: vid_pattern_gen

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, active lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- vid_clk, in, 1, pixel clock
- rst, in, 1, synchronous active-high reset
- enable, in, 1, run timing when high
- pattern_sel, in, 2, 0 bars / 1 ramp / 2 checker / 3 solid
- solid_rgb, in, 24, colour for pattern 3
- hsync, out, 1, active-high line sync
- vsync_n, out, 1, active-low frame sync
- de, out, 1, active-video qualifier
- rgb_data, out, 24, pixel {red,blue,green}
- frame_cnt, out, 16, completed-frame count

REQ-003 Reset SHALL be rst, synchronous, active-high, on clock vid_clk.

Function
REQ-004 The block SHALL run a two-state machine, IDLE and RUN; IDLE->RUN when enable=1; RUN->IDLE on the cycle after enable=0, at any position, with no frame completion.
REQ-005 In RUN, h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP), then wrap to 0.
REQ-006 v_cnt SHALL increment on h wrap, counting 0..V_TOTAL-1 (V_TOTAL = sum of V_* parameters), then wrap to 0.
REQ-007 In IDLE, h_cnt and v_cnt SHALL be held at 0, so the first RUN cycle is pixel (0,0).
REQ-008 All outputs SHALL be registered with exactly 1 cycle latency from the counter position they describe; hsync, vsync_n, de and rgb_data SHALL remain mutually aligned.
REQ-009 de SHALL be 1 iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-010 hsync SHALL be 1 iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, on every line.
REQ-011 vsync_n SHALL be 0 iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, for whole lines.
REQ-012 When de=0, rgb_data SHALL be 24'h0.
REQ-013 Pattern 0 SHALL produce 8 vertical bars, each BAR_W=H_ACTIVE/8 pixels wide, in the order white, yellow, cyan, green, magenta, red, blue, black. The bar index SHALL come from a bar counter cleared at h_cnt=0 (no divider).
REQ-014 Pattern 1 SHALL produce a ramp with red=green=blue=h_cnt[7:0].
REQ-015 Pattern 2 SHALL produce white when h_cnt[5]^v_cnt[5]=1, otherwise black.
REQ-016 Pattern 3 SHALL output solid_rgb unchanged.
REQ-017 pattern_sel and solid_rgb SHALL be sampled only when h_cnt=0 and v_cnt=0 (frame start), and on the IDLE->RUN transition. Mid-frame changes SHALL take effect on the next frame.
REQ-018 frame_cnt SHALL increment by 1, wrapping at 16'hFFFF->0, when v_cnt wraps from V_TOTAL-1 to 0 in RUN. An aborted frame SHALL NOT count.
REQ-019 If enable falls and rises again in consecutive cycles, the block SHALL pass through IDLE for exactly one cycle, then restart at (0,0).

Reset
REQ-020 While rst=1, the block SHALL set state=IDLE, all counters=0, hsync=0, vsync_n=1, de=0, rgb_data=0, frame_cnt=0 and latched pattern=0. rst SHALL take priority over enable.
REQ-021 If rst asserts mid-frame, the outputs SHALL be at reset values on the next edge; after rst deasserts with enable=1, timing SHALL restart at (0,0).

Structure
REQ-022 A shared package vid_pkg SHALL hold the pattern-select encodings, the 8-entry bar colour table, and the state encoding.
REQ-023 There SHALL be one sub-module, vid_timing_cnt, containing the h/v counters and the sync/de decode. Pattern generation and output registers SHALL stay in the top level.

Verification
REQ-024 Default parameters, enable=1 for 2 frames: 800 clocks/line; de high for 640 clocks/line over 480 lines; hsync high for 96 clocks starting 656 clocks after line start; vsync_n low for 2 lines starting at line 490; frame_cnt=2.
REQ-025 Pattern 0: pixel h=0 gives FFFFFF; h=80 gives yellow {FF,00,FF}; h=639 gives 000000; blanking gives 000000.
REQ-026 Pattern 1 then pattern 2: h=300 gives 2C2C2C; pixel (32,0) is white and pixel (32,32) is black.
REQ-027 Switch pattern_sel 0->3 at line 100 with solid_rgb=123456: the current frame stays bars; the next frame gives 123456 at every de pixel.
REQ-028 Deassert enable at (400,200): the next cycle shows de=0, hsync=0, vsync_n=1 and frame_cnt unchanged. Re-enable: the first de pixel appears 1 cycle later at (0,0).
REQ-029 Assert rst for 1 cycle at line 300: all outputs reach reset values and frame_cnt=0; timing restarts at (0,0).

Source files
------------

// File: rtl/vid_pkg.sv
// Shared definitions for the video test-pattern generator: pattern-select
// encodings, FSM state encoding, counter width and the colour-bar table.
// Colours are packed as {red, blue, green}, 8 bits each.
package vid_pkg;

    localparam int unsigned CNT_W    = 16;
    localparam int unsigned NUM_BARS = 8;

    typedef enum logic [1:0] {
        PatBars    = 2'd0,
        PatRamp    = 2'd1,
        PatChecker = 2'd2,
        PatSolid   = 2'd3
    } pattern_e;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;
    localparam logic [23:0] RGB_BLACK = 24'h000000;

    // Left to right: white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [23:0] BAR_COLOURS [NUM_BARS] = '{
        24'hFFFFFF, 24'hFF00FF, 24'h00FFFF, 24'h0000FF,
        24'hFFFF00, 24'hFF0000, 24'h00FF00, 24'h000000
    };

endpackage

// File: rtl/vid_timing_cnt.sv
// Horizontal/vertical raster counters with combinational sync/de decode.
// Ports:
//   vid_clk, rst     pixel clock, synchronous active-high reset
//   advance          step the raster; when low both counters return to 0
//   h_cnt, v_cnt     current raster position
//   h_last           last pixel of a line
//   frame_last       last pixel of a frame
//   de_raw           position lies in the active area
//   hsync_raw        position lies in the hsync pulse (active high)
//   vsync_n_raw      position lies outside the vsync lines (active low)
module vid_timing_cnt import vid_pkg::*; #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic             vid_clk,
    input  logic             rst,
    input  logic             advance,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             h_last,
    output logic             frame_last,
    output logic             de_raw,
    output logic             hsync_raw,
    output logic             vsync_n_raw
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_MAX  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_MAX  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             v_last;

    assign h_last     = (h_q == H_MAX);
    assign v_last     = (v_q == V_MAX);
    assign frame_last = h_last && v_last;

    always_comb begin
        h_d = '0;
        v_d = '0;
        if (advance) begin
            if (h_last) begin
                h_d = '0;
                v_d = v_last ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
                v_d = v_q;
            end
        end
    end

    always_ff @(posedge vid_clk) begin
        if (rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_cnt       = h_q;
    assign v_cnt       = v_q;
    assign de_raw      = (h_q < H_ACT) && (v_q < V_ACT);
    assign hsync_raw   = (h_q >= HS_BEG) && (h_q < HS_END);
    assign vsync_n_raw = !((v_q >= VS_BEG) && (v_q < VS_END));

endmodule

// File: rtl/vid_pattern_gen.sv
// Video timing and test-pattern generator.
// Ports:
//   vid_clk, rst   pixel clock, synchronous active-high reset
//   enable         run the raster; dropping it aborts the frame
//   pattern_sel    0 bars, 1 ramp, 2 checker, 3 solid (latched per frame)
//   solid_rgb      colour for the solid pattern (latched per frame)
//   hsync          active-high line sync
//   vsync_n        active-low frame sync
//   de             active-video qualifier
//   rgb_data       pixel {red, blue, green}, zero outside active video
//   frame_cnt      number of completed frames
// All outputs are registered one cycle after the raster position they describe.
module vid_pattern_gen import vid_pkg::*; #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic        vid_clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [23:0] solid_rgb,
    output logic        hsync,
    output logic        vsync_n,
    output logic        de,
    output logic [23:0] rgb_data,
    output logic [15:0] frame_cnt
);

    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(H_ACTIVE / NUM_BARS - 1);

    state_e state_q, state_d;
    logic   run;

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             h_last, frame_last;
    logic             de_raw, hsync_raw, vsync_n_raw;

    logic             frame_start, sample;
    pattern_e         pat_q, pat_cur;
    logic [23:0]      solid_q, solid_cur;
    logic [CNT_W-1:0] bar_px_q, bar_px_d;
    logic [2:0]       bar_idx_q, bar_idx_d;
    logic [23:0]      pix;

    // Raster advances only while running with enable still high; a low enable
    // in RUN aborts the frame immediately.
    assign run = (state_q == StRun) && enable;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (enable)  state_d = StRun;
            StRun:  if (!enable) state_d = StIdle;
        endcase
    end

    always_ff @(posedge vid_clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    vid_timing_cnt #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .vid_clk     (vid_clk),
        .rst         (rst),
        .advance     (run),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .h_last      (h_last),
        .frame_last  (frame_last),
        .de_raw      (de_raw),
        .hsync_raw   (hsync_raw),
        .vsync_n_raw (vsync_n_raw)
    );

    // Pattern inputs are captured at frame start and on entry to RUN. Pixel
    // (0,0) uses the live inputs so the whole frame sees the same selection.
    assign frame_start = run && (h_cnt == '0) && (v_cnt == '0);
    assign sample      = frame_start || ((state_q == StIdle) && enable);
    assign pat_cur     = frame_start ? pattern_e'(pattern_sel) : pat_q;
    assign solid_cur   = frame_start ? solid_rgb : solid_q;

    always_ff @(posedge vid_clk) begin
        if (rst) begin
            pat_q   <= PatBars;
            solid_q <= '0;
        end else if (sample) begin
            pat_q   <= pattern_e'(pattern_sel);
            solid_q <= solid_rgb;
        end
    end

    // Bar position tracks h_cnt: both are 0 at line start and step together.
    always_comb begin
        bar_px_d  = '0;
        bar_idx_d = '0;
        if (run && !h_last) begin
            if (bar_px_q == BAR_LAST) begin
                bar_px_d  = '0;
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_px_d  = bar_px_q + 1'b1;
                bar_idx_d = bar_idx_q;
            end
        end
    end

    always_ff @(posedge vid_clk) begin
        if (rst) begin
            bar_px_q  <= '0;
            bar_idx_q <= '0;
        end else begin
            bar_px_q  <= bar_px_d;
            bar_idx_q <= bar_idx_d;
        end
    end

    always_comb begin
        pix = RGB_BLACK;
        unique case (pat_cur)
            PatBars:    pix = BAR_COLOURS[bar_idx_q];
            PatRamp:    pix = {3{h_cnt[7:0]}};
            PatChecker: pix = (h_cnt[5] ^ v_cnt[5]) ? RGB_WHITE : RGB_BLACK;
            PatSolid:   pix = solid_cur;
        endcase
    end

    always_ff @(posedge vid_clk) begin
        if (rst || !run) begin
            hsync    <= 1'b0;
            vsync_n  <= 1'b1;
            de       <= 1'b0;
            rgb_data <= '0;
        end else begin
            hsync    <= hsync_raw;
            vsync_n  <= vsync_n_raw;
            de       <= de_raw;
            rgb_data <= de_raw ? pix : '0;
        end
    end

    always_ff @(posedge vid_clk) begin
        if (rst)                    frame_cnt <= '0;
        else if (run && frame_last) frame_cnt <= frame_cnt + 16'd1;
    end

endmodule

// File: tb/tb_vid_pattern_gen.sv
module tb_vid_pattern_gen;

    localparam int HA = 64;
    localparam int HF = 4;
    localparam int HS = 8;
    localparam int HB = 4;
    localparam int VA = 40;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 4;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int BAR_W = HA / 8;

    logic        vid_clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [23:0] solid_rgb = 24'h0;
    logic        hsync, vsync_n, de;
    logic [23:0] rgb_data;
    logic [15:0] frame_cnt;

    always #5 vid_clk = ~vid_clk;

    vid_pattern_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
    ) dut (
        .vid_clk     (vid_clk),
        .rst         (rst),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .solid_rgb   (solid_rgb),
        .hsync       (hsync),
        .vsync_n     (vsync_n),
        .de          (de),
        .rgb_data    (rgb_data),
        .frame_cnt   (frame_cnt)
    );

    typedef struct packed {
        logic        hs;
        logic        vsn;
        logic        de;
        logic [23:0] rgb;
        logic [15:0] fc;
    } out_t;

    typedef struct {
        logic [1:0]  pat;
        logic [23:0] solid;
        int          h;
        int          v;
        logic [23:0] exp_rgb;
    } vec_t;

    out_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state (position of the pixel about to be registered)
    bit          m_run = 0;
    int          m_h = 0;
    int          m_v = 0;
    logic [1:0]  m_pat = 2'd0;
    logic [23:0] m_solid = 24'h0;
    logic [15:0] m_frames = 16'h0;

    function automatic logic [23:0] bar_colour(int idx);
        case (idx)
            0: return 24'hFFFFFF;
            1: return 24'hFF00FF;
            2: return 24'h00FFFF;
            3: return 24'h0000FF;
            4: return 24'hFFFF00;
            5: return 24'hFF0000;
            6: return 24'h00FF00;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [23:0] colour(logic [1:0] p, int h, int v, logic [23:0] s);
        logic [7:0] r;
        r = 8'(h);
        case (p)
            2'd0: return bar_colour(h / BAR_W);
            2'd1: return {r, r, r};
            2'd2: return ((((h >> 5) ^ (v >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            default: return s;
        endcase
    endfunction

    task automatic model_eval(output out_t e);
        e = '{hs: 1'b0, vsn: 1'b1, de: 1'b0, rgb: 24'h0, fc: m_frames};
        if (rst) begin
            m_run = 0; m_h = 0; m_v = 0; m_pat = 2'd0; m_frames = 16'h0;
            e.fc = 16'h0;
        end else if (m_run && enable) begin
            if (m_h == 0 && m_v == 0) begin
                m_pat = pattern_sel;
                m_solid = solid_rgb;
            end
            e.de  = (m_h < HA) && (m_v < VA);
            e.hs  = (m_h >= HA + HF) && (m_h < HA + HF + HS);
            e.vsn = !((m_v >= VA + VF) && (m_v < VA + VF + VS));
            e.rgb = e.de ? colour(m_pat, m_h, m_v, m_solid) : 24'h0;
            if (m_h == HT - 1 && m_v == VT - 1) m_frames = m_frames + 16'd1;
            e.fc = m_frames;
            if (m_h == HT - 1) begin
                m_h = 0;
                m_v = (m_v == VT - 1) ? 0 : m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
        end else begin
            if (m_run) begin
                m_run = 0;
            end else if (enable) begin
                m_run = 1;
                m_pat = pattern_sel;
                m_solid = solid_rgb;
            end
            m_h = 0;
            m_v = 0;
        end
    endtask

    task automatic finish_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // Scoreboard: compare every registered output against the model
    always @(posedge vid_clk) begin
        out_t e, g;
        #1;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            g = {hsync, vsync_n, de, rgb_data, frame_cnt};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL outputs t=%0t got hs=%b vsn=%b de=%b rgb=%h fc=%0d expected hs=%b vsn=%b de=%b rgb=%h fc=%0d",
                         $time, g.hs, g.vsn, g.de, g.rgb, g.fc, e.hs, e.vsn, e.de, e.rgb, e.fc);
            end
        end
    end

    task automatic step();
        out_t e;
        model_eval(e);
        sb_q.push_back(e);
        @(posedge vid_clk);
        #2;
        if (errors > 40) finish_run();
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Step until the model is about to register pixel (h,v)
    task automatic wait_pos(int h, int v);
        int n = 0;
        while (!(m_run && enable && m_h == h && m_v == v) && n < 10000) begin
            step();
            n++;
        end
        if (n >= 10000) begin
            checks++;
            errors++;
            $display("FAIL wait_pos timeout got no (%0d,%0d) expected reach", h, v);
            finish_run();
        end
    endtask

    task automatic goto_px(int h, int v);
        wait_pos(h, v);
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    vec_t tbl[15];

    initial begin
        int de_tot, hs_tot, vsn_tot, hs_first, de_rise2;
        logic de_prev;

        tbl[0]  = '{2'd0, 24'h0, 0,  0,  24'hFFFFFF};
        tbl[1]  = '{2'd0, 24'h0, 8,  0,  24'hFF00FF};
        tbl[2]  = '{2'd0, 24'h0, 16, 1,  24'h00FFFF};
        tbl[3]  = '{2'd0, 24'h0, 24, 0,  24'h0000FF};
        tbl[4]  = '{2'd0, 24'h0, 32, 2,  24'hFFFF00};
        tbl[5]  = '{2'd0, 24'h0, 47, 0,  24'hFF0000};
        tbl[6]  = '{2'd0, 24'h0, 48, 0,  24'h00FF00};
        tbl[7]  = '{2'd0, 24'h0, 63, 0,  24'h000000};
        tbl[8]  = '{2'd0, 24'h0, 64, 0,  24'h000000};
        tbl[9]  = '{2'd1, 24'h0, 44, 0,  24'h2C2C2C};
        tbl[10] = '{2'd1, 24'h0, 63, 1,  24'h3F3F3F};
        tbl[11] = '{2'd2, 24'h0, 32, 0,  24'hFFFFFF};
        tbl[12] = '{2'd2, 24'h0, 32, 32, 24'h000000};
        tbl[13] = '{2'd2, 24'h0, 0,  32, 24'hFFFFFF};
        tbl[14] = '{2'd3, 24'hABCDEF, 10, 3, 24'hABCDEF};

        // Reset state, with enable high to show rst priority
        rst = 1'b1;
        enable = 1'b1;
        step();
        chk("rst_hsync", 32'(hsync), 32'd0);
        chk("rst_vsync_n", 32'(vsync_n), 32'd1);
        chk("rst_de", 32'(de), 32'd0);
        chk("rst_rgb", 32'(rgb_data), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        rst = 1'b0;

        // Pixel table
        for (int i = 0; i < 15; i++) begin
            do_reset();
            pattern_sel = tbl[i].pat;
            solid_rgb = tbl[i].solid;
            enable = 1'b1;
            goto_px(tbl[i].h, tbl[i].v);
            chk($sformatf("tbl%0d_rgb", i), 32'(rgb_data), 32'(tbl[i].exp_rgb));
        end

        // Two full frames of timing
        do_reset();
        pattern_sel = 2'd0;
        enable = 1'b1;
        step();
        de_tot = 0; hs_tot = 0; vsn_tot = 0; hs_first = -1; de_rise2 = -1; de_prev = 1'b0;
        for (int k = 0; k < 2 * HT * VT; k++) begin
            step();
            if (de) de_tot++;
            if (hsync) hs_tot++;
            if (!vsync_n) vsn_tot++;
            if (hsync && hs_first < 0) hs_first = k;
            if (de && !de_prev && k > 0 && de_rise2 < 0) de_rise2 = k;
            de_prev = de;
        end
        chk("de_total", 32'(de_tot), 32'(2 * HA * VA));
        chk("hsync_total", 32'(hs_tot), 32'(2 * HS * VT));
        chk("vsync_low_total", 32'(vsn_tot), 32'(2 * VS * HT));
        chk("hsync_start", 32'(hs_first), 32'(HA + HF));
        chk("line_length", 32'(de_rise2), 32'(HT));
        chk("two_frames", 32'(frame_cnt), 32'd2);

        // Mid-frame pattern change takes effect on the next frame
        do_reset();
        pattern_sel = 2'd0;
        enable = 1'b1;
        goto_px(0, 10);
        pattern_sel = 2'd3;
        solid_rgb = 24'h123456;
        goto_px(8, 11);
        chk("switch_same_frame", 32'(rgb_data), 32'hFF00FF);
        goto_px(5, 3);
        chk("switch_next_frame", 32'(rgb_data), 32'h123456);

        // Abort at (40,20), then re-enable
        wait_pos(40, 20);
        enable = 1'b0;
        step();
        chk("abort_de", 32'(de), 32'd0);
        chk("abort_hsync", 32'(hsync), 32'd0);
        chk("abort_vsync_n", 32'(vsync_n), 32'd1);
        chk("abort_frame_cnt", 32'(frame_cnt), 32'd1);
        enable = 1'b1;
        step();
        chk("reenable_idle_de", 32'(de), 32'd0);
        step();
        chk("reenable_first_de", 32'(de), 32'd1);
        chk("reenable_first_rgb", 32'(rgb_data), 32'h123456);

        // One-cycle enable drop
        wait_pos(10, 2);
        enable = 1'b0;
        step();
        enable = 1'b1;
        step();
        chk("blip_idle_de", 32'(de), 32'd0);
        step();
        chk("blip_restart_de", 32'(de), 32'd1);
        chk("blip_frame_cnt", 32'(frame_cnt), 32'd1);

        // One-cycle reset mid-frame with enable held high
        wait_pos(0, 30);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_de", 32'(de), 32'd0);
        chk("midrst_vsync_n", 32'(vsync_n), 32'd1);
        chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
        step();
        chk("midrst_idle_de", 32'(de), 32'd0);
        step();
        chk("midrst_restart_de", 32'(de), 32'd1);
        chk("midrst_restart_rgb", 32'(rgb_data), 32'h123456);
        goto_px(0, 1);
        chk("midrst_line1_rgb", 32'(rgb_data), 32'h123456);

        finish_run();
    end

endmodule
